// File: rtl/color_histogram_pkg.sv
// Shared image geometry, widths and state encoding for the colour histogram
// and the centroid stage that consumes its bin sums.
package color_histogram_pkg;

  localparam int c_img_cols        = 160;
  localparam int c_img_rows        = 120;
  localparam int c_nb_cols         = $clog2(c_img_cols);
  localparam int c_nb_rows         = $clog2(c_img_rows);
  localparam int c_inframe_cols    = 128;
  localparam int c_inframe_rows    = 104;
  localparam int c_nb_inframe_pxls = $clog2(c_inframe_cols * c_inframe_rows);
  localparam int c_hist_bins       = 8;
  localparam int c_nb_hist_val     = $clog2(c_inframe_rows * c_inframe_cols / c_hist_bins);
  localparam int c_nb_bin          = $clog2(c_hist_bins);
  localparam int c_nb_bin_cols     = $clog2(c_inframe_cols / c_hist_bins);
  localparam int c_nb_half         = c_nb_inframe_pxls - 1;

  localparam logic [c_nb_cols-1:0] c_col_lo   = c_nb_cols'((c_img_cols - c_inframe_cols) / 2);
  localparam logic [c_nb_cols-1:0] c_col_hi   = c_nb_cols'((c_img_cols + c_inframe_cols) / 2 - 1);
  localparam logic [c_nb_rows-1:0] c_row_lo   = c_nb_rows'((c_img_rows - c_inframe_rows) / 2);
  localparam logic [c_nb_rows-1:0] c_row_hi   = c_nb_rows'((c_img_rows + c_inframe_rows) / 2 - 1);
  localparam logic [c_nb_cols-1:0] c_col_last = c_nb_cols'(c_img_cols - 1);
  localparam logic [c_nb_rows-1:0] c_row_last = c_nb_rows'(c_img_rows - 1);

  typedef enum logic [1:0] {
    S_ACC  = 2'd0,
    S_SNAP = 2'd1,
    S_SUM  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Widen a bin count to the half-frame sum width.
  function automatic logic [c_nb_half-1:0] zext_bin(input logic [c_nb_hist_val-1:0] v);
    return {{(c_nb_half - c_nb_hist_val){1'b0}}, v};
  endfunction

endpackage

// File: rtl/color_histogram_if.sv
// Pixel stream in, per-frame histogram results out.
interface color_histogram_if;
  import color_histogram_pkg::*;

  logic                         pxl_valid_i;
  logic [c_nb_cols-1:0]         pxl_col_i;
  logic [c_nb_rows-1:0]         pxl_row_i;
  logic                         pxl_filt_i;
  logic [c_nb_inframe_pxls-1:0] colorpxls_o;
  logic [c_nb_hist_val-1:0]     colorpxls_bin0_o;
  logic [c_nb_hist_val-1:0]     colorpxls_bin7_o;
  logic [c_nb_half-1:0]         colorpxls_left_o;
  logic [c_nb_half-1:0]         colorpxls_rght_o;
  logic [c_nb_half-1:0]         colorpxls_bin012_o;
  logic [c_nb_half-1:0]         colorpxls_bin567_o;
  logic [c_nb_half-1:0]         colorpxls_bin01_o;
  logic [c_nb_half-1:0]         colorpxls_bin67_o;
  logic                         new_frame_proc_o;

  modport master (
    output pxl_valid_i, pxl_col_i, pxl_row_i, pxl_filt_i,
    input  colorpxls_o, colorpxls_bin0_o, colorpxls_bin7_o,
           colorpxls_left_o, colorpxls_rght_o, colorpxls_bin012_o,
           colorpxls_bin567_o, colorpxls_bin01_o, colorpxls_bin67_o,
           new_frame_proc_o
  );

  modport slave (
    input  pxl_valid_i, pxl_col_i, pxl_row_i, pxl_filt_i,
    output colorpxls_o, colorpxls_bin0_o, colorpxls_bin7_o,
           colorpxls_left_o, colorpxls_rght_o, colorpxls_bin012_o,
           colorpxls_bin567_o, colorpxls_bin01_o, colorpxls_bin67_o,
           new_frame_proc_o
  );

endinterface

// File: rtl/color_histogram_hist_bin_cnt.sv
// One column-bin hit counter; clr_load restarts it from the current hit so
// a pixel arriving on the restart cycle is still counted.
module color_histogram_hist_bin_cnt
  import color_histogram_pkg::*;
#(
  parameter int W = c_nb_hist_val
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_load,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // count register: reset, restart from this cycle's hit, or accumulate
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr_load) begin
      cnt_r <= {{(W-1){1'b0}}, inc};
    end else if (inc) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/color_histogram.sv
// Counts colour-filtered pixels per column bin inside the inner frame and
// publishes totals and grouped bin sums three cycles after the last pixel.
module color_histogram
  import color_histogram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  color_histogram_if.slave bus
);

  state_t                       state_r, state_s;
  logic                         hit_s, start_s, last_s, snap_s, sum_s, clr_load_s;
  logic [c_nb_bin-1:0]          bin_s;
  logic [c_nb_hist_val-1:0]     cnt_s  [c_hist_bins];
  logic [c_nb_hist_val-1:0]     hold_r [c_hist_bins];
  logic [c_nb_half-1:0]         left_s, rght_s, b012_s, b567_s, b01_s, b67_s;
  logic [c_nb_inframe_pxls-1:0] total_r;
  logic [c_nb_hist_val-1:0]     bin0_r, bin7_r;
  logic [c_nb_half-1:0]         left_r, rght_r, b012_r, b567_r, b01_r, b67_r;
  logic                         new_frame_r;

  // pixel classification: inner-frame hit, bin index, frame boundaries
  always_comb begin
    hit_s   = bus.pxl_valid_i && bus.pxl_filt_i
              && (bus.pxl_col_i >= c_col_lo) && (bus.pxl_col_i <= c_col_hi)
              && (bus.pxl_row_i >= c_row_lo) && (bus.pxl_row_i <= c_row_hi);
    bin_s   = c_nb_bin'((bus.pxl_col_i - c_col_lo) >> c_nb_bin_cols);
    start_s = bus.pxl_valid_i && (bus.pxl_col_i == {c_nb_cols{1'b0}})
              && (bus.pxl_row_i == {c_nb_rows{1'b0}}) && (state_r == S_ACC);
    last_s  = bus.pxl_valid_i && (bus.pxl_col_i == c_col_last)
              && (bus.pxl_row_i == c_row_last);
  end

  assign clr_load_s = start_s || snap_s;

  for (genvar i = 0; i < c_hist_bins; i++) begin : g_bin
    localparam logic [c_nb_bin-1:0] c_idx = c_nb_bin'(i);
    color_histogram_hist_bin_cnt #(.W(c_nb_hist_val)) u_hist_bin_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr_load (clr_load_s),
      .inc      (hit_s && (bin_s == c_idx)),
      .cnt      (cnt_s[i])
    );
  end

  // frame-phase state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_ACC;
    end else begin
      state_r <= state_s;
    end
  end

  // next phase and per-phase strobes; counting never stalls in any phase
  always_comb begin
    state_s = state_r;
    snap_s  = 1'b0;
    sum_s   = 1'b0;
    case (state_r)
      S_ACC: begin
        if (last_s) begin
          state_s = S_SNAP;
        end else begin
          state_s = S_ACC;
        end
      end
      S_SNAP: begin
        snap_s  = 1'b1;
        state_s = S_SUM;
      end
      S_SUM: begin
        sum_s   = 1'b1;
        state_s = S_OUT;
      end
      S_OUT: begin
        state_s = S_ACC;
      end
      default: begin
        state_s = S_ACC;
      end
    endcase
  end

  // freeze the finished frame's bins while the counters restart
  always_ff @(posedge clk) begin
    for (int i = 0; i < c_hist_bins; i++) begin
      if (!rst) begin
        hold_r[i] <= {c_nb_hist_val{1'b0}};
      end else if (snap_s) begin
        hold_r[i] <= cnt_s[i];
      end else begin
        hold_r[i] <= hold_r[i];
      end
    end
  end

  // grouped sums, built outward from the frame edges
  always_comb begin
    b01_s  = zext_bin(hold_r[0]) + zext_bin(hold_r[1]);
    b012_s = b01_s + zext_bin(hold_r[2]);
    left_s = b012_s + zext_bin(hold_r[3]);
    b67_s  = zext_bin(hold_r[6]) + zext_bin(hold_r[7]);
    b567_s = b67_s + zext_bin(hold_r[5]);
    rght_s = b567_s + zext_bin(hold_r[4]);
  end

  // result registers; the pulse lands in the same cycle the results change
  always_ff @(posedge clk) begin
    if (!rst) begin
      total_r     <= {c_nb_inframe_pxls{1'b0}};
      bin0_r      <= {c_nb_hist_val{1'b0}};
      bin7_r      <= {c_nb_hist_val{1'b0}};
      left_r      <= {c_nb_half{1'b0}};
      rght_r      <= {c_nb_half{1'b0}};
      b012_r      <= {c_nb_half{1'b0}};
      b567_r      <= {c_nb_half{1'b0}};
      b01_r       <= {c_nb_half{1'b0}};
      b67_r       <= {c_nb_half{1'b0}};
      new_frame_r <= 1'b0;
    end else begin
      new_frame_r <= sum_s;
      if (sum_s) begin
        total_r <= {1'b0, left_s} + {1'b0, rght_s};
        bin0_r  <= hold_r[0];
        bin7_r  <= hold_r[7];
        left_r  <= left_s;
        rght_r  <= rght_s;
        b012_r  <= b012_s;
        b567_r  <= b567_s;
        b01_r   <= b01_s;
        b67_r   <= b67_s;
      end
    end
  end

  assign bus.colorpxls_o        = total_r;
  assign bus.colorpxls_bin0_o   = bin0_r;
  assign bus.colorpxls_bin7_o   = bin7_r;
  assign bus.colorpxls_left_o   = left_r;
  assign bus.colorpxls_rght_o   = rght_r;
  assign bus.colorpxls_bin012_o = b012_r;
  assign bus.colorpxls_bin567_o = b567_r;
  assign bus.colorpxls_bin01_o  = b01_r;
  assign bus.colorpxls_bin67_o  = b67_r;
  assign bus.new_frame_proc_o   = new_frame_r;

endmodule

// File: tb/tb_color_histogram.sv
// Directed bench for color_histogram: sparse pixel streams (only pixels that
// matter are sent valid) with hand-computed bin sums and pulse timing.
module tb_color_histogram;
  import color_histogram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  color_histogram_if bus ();

  color_histogram dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int     checks    = 0;
  int     errors    = 0;
  int     cyc_r     = 0;
  int     pulse_cnt = 0;
  int     pulse_cyc = -1;
  int     sent_cyc  = 0;
  integer got   [9];
  integer exp_v [9];
  string  nm    [9] = '{"total", "bin0", "bin7", "left", "rght",
                        "bin012", "bin567", "bin01", "bin67"};

  // cycle counter and pulse monitor, sampled at the active edge
  always @(posedge clk) begin
    cyc_r <= cyc_r + 1;
    if (bus.new_frame_proc_o === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      pulse_cyc <= cyc_r;
    end
  end

  task automatic pix(input int col, input int row, input logic filt);
    bus.pxl_valid_i = 1'b1;
    bus.pxl_col_i   = c_nb_cols'(col);
    bus.pxl_row_i   = c_nb_rows'(row);
    bus.pxl_filt_i  = filt;
    sent_cyc        = cyc_r;
    @(posedge clk);
    #1;
    bus.pxl_valid_i = 1'b0;
    bus.pxl_filt_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic grab();
    got[0] = bus.colorpxls_o;
    got[1] = bus.colorpxls_bin0_o;
    got[2] = bus.colorpxls_bin7_o;
    got[3] = bus.colorpxls_left_o;
    got[4] = bus.colorpxls_rght_o;
    got[5] = bus.colorpxls_bin012_o;
    got[6] = bus.colorpxls_bin567_o;
    got[7] = bus.colorpxls_bin01_o;
    got[8] = bus.colorpxls_bin67_o;
  endtask

  // mode 0: whole inner frame, 1: ring just outside it, 2: col 16, 3: col 143
  task automatic frame_body(input int mode);
    case (mode)
      0: for (int r = 8; r <= 111; r++) for (int c = 16; c <= 143; c++) pix(c, r, 1'b1);
      1: begin
        for (int c = 0; c < 160; c++) pix(c, 7, 1'b1);
        for (int c = 0; c < 160; c++) pix(c, 112, 1'b1);
        for (int r = 0; r < 120; r++) begin
          pix(15, r, 1'b1);
          pix(144, r, 1'b1);
        end
      end
      2: for (int r = 8; r <= 111; r++) pix(16, r, 1'b1);
      3: for (int r = 8; r <= 111; r++) pix(143, r, 1'b1);
      default: ;
    endcase
  endtask

  task automatic send_frame(input int mode);
    pix(0, 0, 1'b0);
    frame_body(mode);
    pix(159, 119, 1'b1);
  endtask

  task automatic test_reset();
    bus.pxl_valid_i = 1'b0;
    bus.pxl_col_i   = '0;
    bus.pxl_row_i   = '0;
    bus.pxl_filt_i  = 1'b0;
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(1);
    exp_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    grab();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL reset_%s: got %0d expected %0d", nm[i], got[i], exp_v[i]);
      end
    end
    checks++;
    if (bus.new_frame_proc_o !== 1'b0 || pulse_cnt != 0) begin
      errors++;
      $display("FAIL reset_pulse: got %b/%0d expected 0/0", bus.new_frame_proc_o, pulse_cnt);
    end
  endtask

  task automatic test_full_frame();
    int pc0 = pulse_cnt;
    int last;
    send_frame(0);
    last = sent_cyc;
    idle(2);
    checks++;
    if (bus.new_frame_proc_o !== 1'b1) begin
      errors++;
      $display("FAIL full_pulse_coincident: got %b expected 1", bus.new_frame_proc_o);
    end
    exp_v = '{13312, 1664, 1664, 6656, 6656, 4992, 4992, 3328, 3328};
    grab();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL full_%s: got %0d expected %0d", nm[i], got[i], exp_v[i]);
      end
    end
    idle(4);
    checks++;
    if (pulse_cnt != pc0 + 1 || pulse_cyc != last + 3) begin
      errors++;
      $display("FAIL full_pulse_timing: got %0d pulses at +%0d expected 1 at +3",
               pulse_cnt - pc0, pulse_cyc - last);
    end
  endtask

  task automatic test_reset_mid();
    int pc0 = pulse_cnt;
    pix(0, 0, 1'b0);
    for (int r = 8; r <= 9; r++) for (int c = 16; c <= 143; c++) pix(c, r, 1'b1);
    rst = 1'b0;
    for (int c = 16; c < 19; c++) pix(c, 10, 1'b1);
    rst = 1'b1;
    for (int c = 19; c < 24; c++) pix(c, 10, 1'b1);
    idle(6);
    exp_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    grab();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL rstmid_%s: got %0d expected %0d", nm[i], got[i], exp_v[i]);
      end
    end
    checks++;
    if (pulse_cnt != pc0) begin
      errors++;
      $display("FAIL rstmid_no_pulse: got %0d pulses expected 0", pulse_cnt - pc0);
    end
  endtask

  task automatic test_col16();
    int pc0 = pulse_cnt;
    int last;
    send_frame(2);
    last = sent_cyc;
    idle(2);
    exp_v = '{104, 104, 0, 104, 0, 104, 0, 104, 0};
    grab();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL col16_%s: got %0d expected %0d", nm[i], got[i], exp_v[i]);
      end
    end
    idle(4);
    checks++;
    if (pulse_cnt != pc0 + 1 || pulse_cyc != last + 3) begin
      errors++;
      $display("FAIL col16_pulse: got %0d pulses at +%0d expected 1 at +3",
               pulse_cnt - pc0, pulse_cyc - last);
    end
  endtask

  task automatic test_border();
    int pc0 = pulse_cnt;
    send_frame(1);
    idle(6);
    exp_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    grab();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL border_%s: got %0d expected %0d", nm[i], got[i], exp_v[i]);
      end
    end
    checks++;
    if (pulse_cnt != pc0 + 1) begin
      errors++;
      $display("FAIL border_pulse: got %0d pulses expected 1", pulse_cnt - pc0);
    end
  endtask

  task automatic test_abort();
    int pc0 = pulse_cnt;
    pix(0, 0, 1'b0);
    for (int r = 8; r <= 15; r++) for (int c = 16; c <= 143; c++) pix(c, r, 1'b1);
    send_frame(3);
    idle(6);
    exp_v = '{104, 0, 104, 0, 104, 0, 104, 0, 104};
    grab();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL abort_%s: got %0d expected %0d", nm[i], got[i], exp_v[i]);
      end
    end
    checks++;
    if (pulse_cnt != pc0 + 1) begin
      errors++;
      $display("FAIL abort_pulse_count: got %0d pulses expected 1", pulse_cnt - pc0);
    end
  endtask

  task automatic test_back_to_back();
    int pc0 = pulse_cnt;
    int last_a;
    int last_b;
    send_frame(0);
    last_a = sent_cyc;
    pix(0, 0, 1'b0);
    pix(16, 8, 1'b1);
    checks++;
    if (bus.new_frame_proc_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_a_pulse: got %b expected 1", bus.new_frame_proc_o);
    end
    exp_v = '{13312, 1664, 1664, 6656, 6656, 4992, 4992, 3328, 3328};
    grab();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL b2b_a_%s: got %0d expected %0d", nm[i], got[i], exp_v[i]);
      end
    end
    pix(16, 9, 1'b1);
    checks++;
    if (pulse_cyc != last_a + 3) begin
      errors++;
      $display("FAIL b2b_a_timing: got +%0d expected +3", pulse_cyc - last_a);
    end
    for (int r = 10; r <= 111; r++) pix(16, r, 1'b1);
    pix(159, 119, 1'b1);
    last_b = sent_cyc;
    idle(2);
    exp_v = '{104, 104, 0, 104, 0, 104, 0, 104, 0};
    grab();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL b2b_b_%s: got %0d expected %0d", nm[i], got[i], exp_v[i]);
      end
    end
    idle(4);
    checks++;
    if (pulse_cnt != pc0 + 2 || pulse_cyc != last_b + 3) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d pulses, last at +%0d expected 2, +3",
               pulse_cnt - pc0, pulse_cyc - last_b);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_reset_mid();
    test_col16();
    test_border();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
